// File: rtl/ibex_hpm_counter_bank.sv
// Bank of machine hardware performance counters (mhpmcounter3.., mhpmevent3.., mcountinhibit)
// with sticky per-counter overflow flags; the CSR block decodes, this bank owns state and read data.
module ibex_hpm_counter_bank #(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumEvents-1:0]   event_i,
    input  logic [11:0]            csr_addr_i,
    input  logic                   csr_we_i,
    input  logic [31:0]            csr_wdata_i,
    output logic                   csr_hit_o,
    output logic [31:0]            csr_rdata_o,
    output logic [NumCounters-1:0] overflow_o
);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_INHIBIT,
        SEL_EVENT,
        SEL_CNT_LO,
        SEL_CNT_HI
    } sel_e;

    sel_e       sel;
    logic [4:0] idx;

    logic [CounterWidth-1:0] cnt_q [NumCounters];
    logic [CounterWidth-1:0] cnt_d [NumCounters];
    logic [NumEvents-1:0]    evt_q [NumCounters];
    logic [NumEvents-1:0]    evt_d [NumCounters];
    logic [NumCounters-1:0]  inh_q, inh_d;
    logic [NumCounters-1:0]  ovf_q, ovf_d;

    // Replace the low (bits 31:0) or high (bits CW-1:32) word of a counter.
    function automatic logic [CounterWidth-1:0] write_word(input logic [CounterWidth-1:0] cur,
                                                           input logic [31:0] wdata,
                                                           input logic hi);
        logic [CounterWidth-1:0] res;
        res = cur;
        for (int b = 0; b < int'(CounterWidth); b++) begin
            if ((b >= 32) == hi) res[b] = wdata[b % 32];
        end
        return res;
    endfunction

    function automatic logic [31:0] read_word(input logic [CounterWidth-1:0] cur, input logic hi);
        logic [31:0] res;
        res = '0;
        for (int b = 0; b < int'(CounterWidth); b++) begin
            if ((b >= 32) == hi) res[b % 32] = cur[b];
        end
        return res;
    endfunction

    // The three per-counter windows share the low five address bits: index = addr[4:0] - 3.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        sel = SEL_NONE;
        idx = csr_addr_i[4:0] - 5'd3;
        if (csr_addr_i == 12'h320) begin
            sel = SEL_INHIBIT;
        end else if (csr_addr_i[4:0] >= 5'd3) begin
            case (csr_addr_i[11:5])
                7'h19:   sel = SEL_EVENT;
                7'h58:   sel = SEL_CNT_LO;
                7'h5C:   sel = SEL_CNT_HI;
                default: sel = SEL_NONE;
            endcase
        end
    end

    assign csr_hit_o = (sel != SEL_NONE);

    always_comb begin
        inh_d = inh_q;
        ovf_d = ovf_q;
        if (csr_we_i && sel == SEL_INHIBIT) inh_d = csr_wdata_i[3 +: NumCounters];
        for (int k = 0; k < int'(NumCounters); k++) begin
            cnt_d[k] = cnt_q[k];
            evt_d[k] = evt_q[k];
            if (csr_we_i && idx == 5'(k) && sel == SEL_EVENT) evt_d[k] = csr_wdata_i[NumEvents-1:0];
            // A counter write wins over the increment and over a concurrent wrap.
            if (csr_we_i && idx == 5'(k) && (sel == SEL_CNT_LO || sel == SEL_CNT_HI)) begin
                cnt_d[k] = write_word(cnt_q[k], csr_wdata_i, sel == SEL_CNT_HI);
                ovf_d[k] = 1'b0;
            end else if (|(evt_q[k] & event_i) && !inh_q[k]) begin
                cnt_d[k] = cnt_q[k] + CounterWidth'(1);
                if (&cnt_q[k]) ovf_d[k] = 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        if (sel == SEL_INHIBIT) csr_rdata_o[3 +: NumCounters] = inh_q;
        for (int k = 0; k < int'(NumCounters); k++) begin
            if (idx == 5'(k)) begin
                case (sel)
                    SEL_EVENT:  csr_rdata_o[NumEvents-1:0] = evt_q[k];
                    SEL_CNT_LO: csr_rdata_o = read_word(cnt_q[k], 1'b0);
                    SEL_CNT_HI: csr_rdata_o = read_word(cnt_q[k], 1'b1);
                    default:    ;
                endcase
            end
        end
    end

    // Counters are individual flops rather than a RAM, so the synchronous reset clears them all.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_ni) begin
            inh_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < int'(NumCounters); k++) begin
                cnt_q[k] <= '0;
                evt_q[k] <= '0;
            end
        end else begin
            inh_q <= inh_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Scoreboard bench for ibex_hpm_counter_bank: directed scenarios plus random CSR traffic,
// checked against an arithmetic reference model of the counter bank.
module tb_ibex_hpm_counter_bank;

    localparam int NC = 8;
    localparam int CW = 40;
    localparam int NE = 16;
    localparam logic [63:0] CMask = (64'd1 << CW) - 64'd1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NE-1:0] event_i;
    logic [11:0]   csr_addr_i;
    logic          csr_we_i;
    logic [31:0]   csr_wdata_i;
    logic          csr_hit_o;
    logic [31:0]   csr_rdata_o;
    logic [NC-1:0] overflow_o;

    ibex_hpm_counter_bank #(
        .NumCounters (NC),
        .CounterWidth(CW),
        .NumEvents   (NE)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .event_i    (event_i),
        .csr_addr_i (csr_addr_i),
        .csr_we_i   (csr_we_i),
        .csr_wdata_i(csr_wdata_i),
        .csr_hit_o  (csr_hit_o),
        .csr_rdata_o(csr_rdata_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0]   addr;
        logic [31:0]   rdata;
        logic          hit;
        logic [NC-1:0] ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    longint unsigned m_cnt [NC];
    logic [NE-1:0]   m_evt [NC];
    logic [31:0]     m_inh;
    logic [NC-1:0]   m_ovf;

    function automatic logic exp_hit(input logic [11:0] a);
        return (a == 12'h320) || (a >= 12'h323 && a <= 12'h33F) ||
               (a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hB83 && a <= 12'hB9F);
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] a);
        int k;
        if (a == 12'h320) return m_inh;
        if (a >= 12'h323 && a <= 12'h33F) begin
            k = int'(a) - 'h323;
            return (k < NC) ? 32'(m_evt[k]) : 32'd0;
        end
        if (a >= 12'hB03 && a <= 12'hB1F) begin
            k = int'(a) - 'hB03;
            return (k < NC) ? 32'(m_cnt[k]) : 32'd0;
        end
        if (a >= 12'hB83 && a <= 12'hB9F) begin
            k = int'(a) - 'hB83;
            return (k < NC) ? 32'(m_cnt[k] >> 32) : 32'd0;
        end
        return 32'd0;
    endfunction

    task automatic model_step(input logic rst, input logic [NE-1:0] ev, input logic [11:0] a,
                              input logic we, input logic [31:0] wd);
        bit inc [NC];
        if (!rst) begin
            for (int k = 0; k < NC; k++) begin
                m_cnt[k] = 0;
                m_evt[k] = '0;
            end
            m_inh = '0;
            m_ovf = '0;
            return;
        end
        // Increment decisions use the configuration in force before this edge.
        for (int k = 0; k < NC; k++) inc[k] = ((m_evt[k] & ev) != 0) && !m_inh[3+k];
        for (int k = 0; k < NC; k++) begin
            if (we && a == 12'(12'hB03 + k)) begin
                m_cnt[k] = ((m_cnt[k] & ~64'hFFFF_FFFF) | 64'(wd)) & CMask;
                m_ovf[k] = 1'b0;
            end else if (we && a == 12'(12'hB83 + k)) begin
                m_cnt[k] = ((64'(wd) << 32) | (m_cnt[k] & 64'hFFFF_FFFF)) & CMask;
                m_ovf[k] = 1'b0;
            end else if (inc[k]) begin
                if (m_cnt[k] == CMask) begin
                    m_cnt[k] = 0;
                    m_ovf[k] = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (we && a == 12'(12'h323 + k)) m_evt[k] = wd[NE-1:0];
        end
        if (we && a == 12'h320) m_inh = wd & (((32'd1 << NC) - 32'd1) << 3);
    endtask

    // One cycle of stimulus: drive, record the expected response, then advance the model at the edge.
    task automatic drive(input logic rst, input logic [NE-1:0] ev, input logic [11:0] a,
                         input logic we, input logic [31:0] wd);
        exp_t e;
        rst_ni      = rst;
        event_i     = ev;
        csr_addr_i  = a;
        csr_we_i    = we;
        csr_wdata_i = wd;
        e.addr  = a;
        e.rdata = exp_read(a);
        e.hit   = exp_hit(a);
        e.ovf   = m_ovf;
        exp_q.push_back(e);
        @(posedge clk_i);
        model_step(rst, ev, a, we, wd);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] a, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s addr=%h actual=%h required=%h", name, a, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("hit", e.addr, 64'(csr_hit_o), 64'(e.hit));
            check("rdata", e.addr, 64'(csr_rdata_o), 64'(e.rdata));
            check("overflow", e.addr, 64'(overflow_o), 64'(e.ovf));
        end
    end

    function automatic logic [11:0] rand_addr();
        logic [11:0] k;
        k = 12'($urandom_range(0, NC + 1));
        case ($urandom_range(0, 9))
            0:       return 12'h320;
            1, 2:    return 12'h323 + k;
            3, 4:    return 12'hB03 + k;
            5, 6:    return 12'hB83 + k;
            7:       return 12'($urandom);
            default: return 12'hB03 + k;
        endcase
    endfunction

    function automatic logic [31:0] rand_wdata();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_00FF;
            2:       return $urandom;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        model_step(1'b0, '0, '0, 1'b0, '0);
        rst_ni = 1'b0; event_i = '0; csr_addr_i = '0; csr_we_i = 1'b0; csr_wdata_i = '0;
        @(posedge clk_i);
        #1;

        // Reset state, then ten cycles of a selected event on counter 3.
        drive(1'b0, '0, 12'hB03, 1'b0, '0);
        drive(1'b1, '0, 12'h323, 1'b1, 32'h1);
        repeat (10) drive(1'b1, 16'h0001, 12'hB03, 1'b0, '0);
        for (int k = 0; k < NC; k++) drive(1'b1, '0, 12'(12'hB03 + k), 1'b0, '0);

        // Wrap of a 40-bit counter, then a low-word write clears the sticky flag.
        drive(1'b1, '0, 12'hB03, 1'b1, 32'hFFFF_FFFF);
        drive(1'b1, '0, 12'hB83, 1'b1, 32'h0000_00FF);
        drive(1'b1, 16'h0001, 12'hB83, 1'b0, '0);
        drive(1'b1, '0, 12'hB03, 1'b0, '0);
        drive(1'b1, '0, 12'hB03, 1'b1, 32'd5);
        drive(1'b1, '0, 12'hB03, 1'b0, '0);

        // Inhibit counter 4 while its event fires, then release it.
        drive(1'b1, '0, 12'h324, 1'b1, 32'h1);
        repeat (3) drive(1'b1, 16'h0001, 12'hB04, 1'b0, '0);
        drive(1'b1, 16'h0001, 12'h320, 1'b1, 32'h10);
        repeat (4) drive(1'b1, 16'h0001, 12'hB04, 1'b0, '0);
        drive(1'b1, 16'h0001, 12'h320, 1'b1, 32'h0);
        repeat (4) drive(1'b1, 16'h0001, 12'hB04, 1'b0, '0);
        drive(1'b1, '0, 12'h320, 1'b0, '0);

        // Write beats a simultaneous increment.
        drive(1'b1, 16'h0001, 12'hB03, 1'b1, 32'h100);
        drive(1'b1, 16'h0001, 12'hB03, 1'b0, '0);
        drive(1'b1, '0, 12'hB03, 1'b0, '0);

        // Unimplemented counter 8 and unowned addresses.
        drive(1'b1, '0, 12'hB0B, 1'b1, 32'h1234);
        drive(1'b1, '0, 12'h32B, 1'b1, 32'hFFFF);
        drive(1'b1, '0, 12'hB8B, 1'b1, 32'h55);
        drive(1'b1, '0, 12'hB0B, 1'b0, '0);
        drive(1'b1, '0, 12'h32B, 1'b0, '0);
        drive(1'b1, '0, 12'h320, 1'b1, 32'hFFFF_FFFF);
        drive(1'b1, '0, 12'h320, 1'b1, 32'h0);
        drive(1'b1, '0, 12'hC00, 1'b0, '0);
        drive(1'b1, '0, 12'h321, 1'b0, '0);
        drive(1'b1, '0, 12'hB02, 1'b0, '0);

        // Two selected events in one cycle count once; reset mid-count clears everything.
        drive(1'b1, '0, 12'h323, 1'b1, 32'h3);
        drive(1'b1, 16'h0003, 12'hB03, 1'b0, '0);
        drive(1'b1, 16'h0003, 12'hB03, 1'b0, '0);
        drive(1'b0, 16'hFFFF, 12'hB03, 1'b1, 32'h77);
        drive(1'b1, '0, 12'hB03, 1'b0, '0);
        drive(1'b1, '0, 12'h323, 1'b0, '0);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 199) != 0), NE'($urandom), rand_addr(),
                  ($urandom_range(0, 3) == 0), rand_wdata());
        end

        repeat (3) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
